// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the instruction memory. Receives a byte stream over
//   a valid/ready handshake, packs bytes little-endian into 32-bit words and
//   writes them at consecutive word-aligned addresses. The core is held in
//   reset (core_hold) until a complete, valid image has been loaded.
//
//   Stream: LEN_LO, LEN_HI (16-bit word count N), 4*N data bytes, and, when
//   IMEM_LOADER_CHECKSUM_EN is defined, one trailing checksum byte equal to
//   the modulo-256 sum of all data bytes.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (checksum byte + CHK state)
//
// Ports:
//   clk        in   clock
//   reset_n    in   synchronous active-low reset
//   start      in   one-cycle pulse starting a load (ignored while busy)
//   rx_data    in   stream byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  loader accepts a byte
//   mem_we     out  memory write strobe, one cycle per word
//   mem_addr   out  word-aligned byte address
//   mem_wdata  out  packed 32-bit word
//   core_hold  out  core held in reset while high
//   busy       out  load in progress
//   done       out  image loaded successfully (sticky)
//   error      out  load failed (sticky)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS) + 1;
    localparam logic [15:0] DEPTH_L = 16'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK    = 3'd5,
`endif
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              core_hold_q, core_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              accept_s;
    logic [15:0]       len_full_s;
    logic [15:0]       idx_inc_s;

    // rx_ready_q always reflects the current state, so it qualifies transfers
    assign accept_s   = rx_valid & rx_ready_q;
    assign len_full_s = {rx_data, len_q[7:0]};
    assign idx_inc_s  = 16'(word_idx_q) + 16'd1;

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    word_idx_d = '0;
                    byte_cnt_d = 2'd0;
                    word_d     = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (accept_s) begin
                    len_d[15:8] = rx_data;
                    if (len_full_s > DEPTH_L) begin
                        state_d = S_ERR;
                    end else if (len_full_s == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = rx_data;
                        2'd1:    word_d[15:8]  = rx_data;
                        2'd2:    word_d[23:16] = rx_data;
                        default: word_d[31:24] = rx_data;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Address and data are latched here so they are stable
                        // for the single WRITE cycle.
                        state_d     = S_WRITE;
                        mem_addr_d  = ADDR_W'({word_idx_q, 2'b00});
                        mem_wdata_d = word_d;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                if (idx_inc_s == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept_s) begin
                    state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
                end else begin
                    state_d = S_CHK;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is registered
    always_comb begin
        rx_ready_d  = 1'b0;
        mem_we_d    = 1'b0;
        core_hold_d = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_LEN_LO, S_LEN_HI, S_DATA: begin
                rx_ready_d = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready_d = 1'b1;
            end
`endif
            S_WRITE: begin
                mem_we_d = 1'b1;
            end
            S_DONE: begin
                done_d      = 1'b1;
                core_hold_d = 1'b0;
                busy_d      = 1'b0;
            end
            S_ERR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            word_idx_q  <= '0;
            byte_cnt_q  <= 2'd0;
            word_q      <= 32'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            core_hold_q <= core_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    // expected writes: {addr[11:0], data[31:0]}
    logic [43:0] exp_q[$];
    logic [31:0] img[8];

    imem_loader #(.ADDR_W(12), .DEPTH_WORDS(128)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every write strobe must match the next expected write
    always @(negedge clk) begin
        logic [43:0] e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[43:32]));
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        int g;
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        @(negedge clk);
        repeat (g) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: got rx_ready %b expected 1", rx_ready);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_rx_ready", 32'(rx_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_core_hold", 32'(core_hold), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_error_clr", 32'(error), 32'd0);
    endtask

    // Header, data words from img[], and checksum when compiled in
    task automatic load(input int n, input int max_gap);
        logic [7:0] sum;
        logic [31:0] w;
        sum = 8'd0;
        for (int i = 0; i < n; i++) exp_q.push_back({12'(i * 4), img[i]});
        send_byte(8'(n), 0);
        send_byte(8'(n >> 8), 0);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int j = 0; j < 4; j++) begin
                send_byte(w[8*j +: 8], max_gap);
                sum = sum + w[8*j +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(sum, 0);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;

        // Two-word image, back-to-back bytes
        img[0] = 32'h0000_0013;
        img[1] = 32'h0000_006F;
        start_load();
        load(2, 0);
        @(negedge clk);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("t1_we_last", 32'(mem_we), 32'd1);
        check("t1_done_early", 32'(done), 32'd0);
        check("t1_rx_ready_wr", 32'(rx_ready), 32'd0);
        @(negedge clk);
`endif
        check("t1_done", 32'(done), 32'd1);
        check("t1_core_hold", 32'(core_hold), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_error", 32'(error), 32'd0);

        // Oversized header
        start_load();
        send_byte(8'h81, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("t2_error", 32'(error), 32'd1);
        check("t2_core_hold", 32'(core_hold), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_done", 32'(done), 32'd0);
        check("t2_rx_ready", 32'(rx_ready), 32'd0);
        // start is not a load; nothing happens without it
        repeat (3) @(negedge clk);
        check("t2_error_sticky", 32'(error), 32'd1);

        // Empty image re-armed from ERR
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        @(negedge clk);
        check("t3_done", 32'(done), 32'd1);
        check("t3_core_hold", 32'(core_hold), 32'd0);

        // Three words with random rx_valid gaps
        img[0] = 32'h1122_3344;
        img[1] = 32'hA5A5_5A5A;
        img[2] = 32'hDEAD_BEEF;
        start_load();
        load(3, 3);
        repeat (2) @(negedge clk);
        check("t4_done", 32'(done), 32'd1);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a word
        start_load();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals("t5");
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_idle_rx_ready", 32'(rx_ready), 32'd0);
        img[0] = 32'h4433_2211;
        start_load();
        load(1, 0);
        repeat (2) @(negedge clk);
        check("t5_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good checksum
        img[0] = 32'h0403_0201;
        start_load();
        load(1, 0);
        @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        check("t6_error", 32'(error), 32'd0);
        // Bad checksum; the word is still written
        start_load();
        exp_q.push_back({12'h000, 32'h0403_0201});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h0B, 0);
        @(negedge clk);
        check("t6_bad_error", 32'(error), 32'd1);
        check("t6_bad_done", 32'(done), 32'd0);
        check("t6_bad_core_hold", 32'(core_hold), 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's 128-word instruction memory. It takes a byte stream from the boot UART receiver through a valid/ready handshake and packs the bytes little-endian into 32-bit words. Each word is written through the memory's write port at consecutive word-aligned addresses. The core is held in reset until a complete, valid image has been loaded.

## Interface
Parameters:
- ADDR_W, 12: byte-address width of the instruction memory port.
- DEPTH_WORDS, 128: memory capacity in words; the maximum accepted image length.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Ignored while busy.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte. A transfer occurs on a rising edge with rx_valid && rx_ready.
- mem_we  out  1  write strobe, one cycle per word.
- mem_addr  out  ADDR_W  byte address, always word-aligned (bits [1:0] = 0).
- mem_wdata  out  32  packed word.
- core_hold  out  1  keeps the core in reset while high.
- busy  out  1  a load is in progress.
- done  out  1  image loaded successfully. Sticky.
- error  out  1  load failed. Sticky.

## Operation
- Stream format:
  - LEN_LO, then LEN_HI: 16-bit word count N, little-endian.
  - Then 4·N data bytes, byte 0 first, placed in word bits [7:0].
  - Then an optional checksum byte (see Configuration).
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK (only when the macro is defined), DONE, ERR.
- IDLE: rx_ready=0. On start, go to LEN_LO and clear the word index, byte counter, done, error and checksum.
- LEN_LO / LEN_HI: rx_ready=1. Capture the length bytes. On LEN_HI acceptance:
  - N > DEPTH_WORDS → ERR.
  - N = 0 → CHK if compiled in, otherwise DONE.
  - Otherwise → DATA.
- DATA: rx_ready=1. Shift each accepted byte into the word buffer at byte lane byte_cnt. When the 4th byte is accepted, go to WRITE.
- WRITE: rx_ready=0 and mem_we=1 for exactly one cycle.
  - mem_addr = word_idx·4; mem_wdata = the packed word.
  - Then word_idx increments.
  - If word_idx+1 = N → CHK or DONE; otherwise → DATA.
- DONE: done=1, core_hold=0, busy=0.
- ERR: error=1, core_hold=1, busy=0.
- From DONE or ERR, a start pulse begins a new load.
- busy is 1 in every state except IDLE, DONE and ERR.
- core_hold is 1 in every state except DONE. A re-load from DONE reasserts core_hold on the cycle after start.
- Words already written before an error are not rolled back.
- Counters: word_idx is ⌈log2(DEPTH_WORDS)⌉+1 bits wide, byte_cnt is 2 bits. No wrap-around is possible because N ≤ DEPTH_WORDS.

## Timing
- All outputs are registered. Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, busy=0, done=0, error=0. State resets to IDLE.
- start sampled at edge t → rx_ready=1 from cycle t+1.
- 4th byte of a word accepted at edge k → mem_we=1 during cycle k+1 only; rx_ready=0 in that cycle. rx_ready returns to 1 in cycle k+2 if more bytes are expected.
- Final write in cycle k+1 → done=1 and core_hold=0 from cycle k+2 (no checksum).
- Throughput is at most 4 bytes per 5 cycles. A stalled rx_valid simply holds the current state.
- start is ignored during LEN_LO through CHK.
- reset_n low at any point: return to reset values on the next edge and discard any partial word. No write is issued in that cycle.

## Configuration
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last write, or directly after LEN_HI when N = 0, go to CHK with rx_ready=1 and accept one byte.
  - The byte must equal the 8-bit modulo-256 sum of all data bytes (length bytes excluded).
  - Match → DONE; mismatch → ERR. The done/error timing is one cycle after the checksum byte is accepted.
- Undefined: the CHK state and the sum logic are absent. The stream ends after the last data byte.

## Test plan
- Reset, then start, then stream 02 00 | 13 00 00 00 | 6F 00 00 00 → writes of 0x00000013 @0x000 and 0x0000006F @0x004. Each mem_we is one cycle. done=1, core_hold=0 two cycles after the last byte.
- Header 81 00 (N=129 > 128) → error=1, core_hold=1, no mem_we; a later start re-arms the loader.
- Header 00 00 → no writes. done follows (checksum builds require a 00 checksum byte first).
- rx_valid toggled randomly during DATA for N=3 → same three words written in order, addresses 0x0, 0x4, 0x8.
- reset_n low after 2 data bytes of word 1 → no write, all outputs at reset values. A fresh load then writes from 0x000.
- With IMEM_LOADER_CHECKSUM_EN: stream 01 00 | 01 02 03 04 | 0A → done. The same stream with checksum 0B → error=1, and the word 0x04030201 remains written @0x000.
